// File: rtl/hazard_stall_controller_pkg.sv
// Shared types and constants for the hazard stall controller.
//   slot_t       : one shadow scoreboard entry {valid, rd, reg_w}
//   REG_ZERO     : hard-wired zero register number
//   R_TYPE       : R-type opcode (used by Control-side decode and the bench)
//   slot_hits()  : true when a slot can still produce a value that src reads
package hazard_stall_controller_pkg;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [5:0] R_TYPE   = 6'b000000;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       reg_w;
    } slot_t;

    localparam int SLOT_W = $bits(slot_t);

    // $0 is never a producer and never a real consumer, so both sides are
    // excluded before the address compare.
    function automatic logic slot_hits(input slot_t s, input logic [4:0] src);
        return s.valid && s.reg_w && (s.rd != REG_ZERO) &&
               (src != REG_ZERO) && (s.rd == src);
    endfunction

endpackage

// File: rtl/hazard_scoreboard_slot.sv
// One shadow scoreboard stage: a slot_t register with synchronous clear.
// Ports:
//   i_clk  : clock
//   i_clr  : synchronous clear (slot becomes invalid)
//   i_d    : next slot contents
//   o_q    : registered slot contents
module hazard_scoreboard_slot
    import hazard_stall_controller_pkg::*;
(
    input  logic  i_clk,
    input  logic  i_clr,
    input  slot_t i_d,
    output slot_t o_q
);

    slot_t r_q;

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_q <= '0;
        end else begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/hazard_stall_controller.sv
// RAW interlock for a five-stage pipeline without forwarding.
// A three-entry shadow scoreboard (EX, MEM, WB) tracks pending register
// writes; the instruction in ID is held until its sources are safe to read.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   id_*              : decoded fields / control of the instruction in ID
//   ext_hold          : external front-end hold request
//   pc_hold           : PC must not update this cycle
//   if_id_hold        : IF_ID keeps its contents
//   id_ex_bubble      : ID_EX captures a NOP with Reg_w=0
//   stall_age         : consecutive held cycles of the current ID instr (sat 3)
//   issued_cnt        : instructions moved from ID to EX (saturating)
//   stall_cnt         : cycles with id_ex_bubble=1 (saturating)
//
// Hold semantics: the three hold outputs are one combinational signal.
// While it is high the instruction in ID must be presented unchanged on the
// next cycle; it is accepted into EX on the first edge where it is low.
module hazard_stall_controller
    import hazard_stall_controller_pkg::*;
#(
    parameter logic WB_BYPASS = 1'b1,
    parameter int   CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs_addr,
    input  logic [4:0]       id_rt_addr,
    input  logic             id_rs_used,
    input  logic             id_rt_used,
    input  logic [4:0]       id_rd_addr,
    input  logic             id_reg_w,
    input  logic             ext_hold,
    output logic             pc_hold,
    output logic             if_id_hold,
    output logic             id_ex_bubble,
    output logic [1:0]       stall_age,
    output logic [CNT_W-1:0] issued_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    slot_t w_ex_s;
    slot_t w_mem_s;
    slot_t w_wb_s;
    slot_t w_ex_d;

    logic w_rs_hit;
    logic w_rt_hit;
    logic w_hazard;
    logic w_stall;

    logic [1:0]       r_stall_age;
    logic [CNT_W-1:0] r_issued_cnt;
    logic [CNT_W-1:0] r_stall_cnt;

    // WB only matters when the register file cannot forward a same-cycle
    // write to the read port.
    always_comb begin
        w_rs_hit = slot_hits(w_ex_s, id_rs_addr) || slot_hits(w_mem_s, id_rs_addr) ||
                   (!WB_BYPASS && slot_hits(w_wb_s, id_rs_addr));
        w_rt_hit = slot_hits(w_ex_s, id_rt_addr) || slot_hits(w_mem_s, id_rt_addr) ||
                   (!WB_BYPASS && slot_hits(w_wb_s, id_rt_addr));
        w_hazard = id_valid && ((id_rs_used && w_rs_hit) || (id_rt_used && w_rt_hit));
        w_stall  = w_hazard || ext_hold;
    end

    // A stalled ID instruction must not also be recorded as entering EX.
    always_comb begin
        w_ex_d = '0;
        if (!w_stall) begin
            w_ex_d.valid = id_valid;
            w_ex_d.rd    = id_rd_addr;
            w_ex_d.reg_w = id_reg_w;
        end
    end

    hazard_scoreboard_slot u_ex_slot (
        .i_clk (clk),
        .i_clr (rst),
        .i_d   (w_ex_d),
        .o_q   (w_ex_s)
    );

    hazard_scoreboard_slot u_mem_slot (
        .i_clk (clk),
        .i_clr (rst),
        .i_d   (w_ex_s),
        .o_q   (w_mem_s)
    );

    hazard_scoreboard_slot u_wb_slot (
        .i_clk (clk),
        .i_clr (rst),
        .i_d   (w_mem_s),
        .o_q   (w_wb_s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_age  <= 2'd0;
            r_issued_cnt <= '0;
            r_stall_cnt  <= '0;
        end else begin
            if (w_stall) begin
                if (r_stall_age != 2'd3) begin
                    r_stall_age <= r_stall_age + 2'd1;
                end
                if (r_stall_cnt != '1) begin
                    r_stall_cnt <= r_stall_cnt + CNT_ONE;
                end
            end else begin
                r_stall_age <= 2'd0;
                if (id_valid && (r_issued_cnt != '1)) begin
                    r_issued_cnt <= r_issued_cnt + CNT_ONE;
                end
            end
        end
    end

    assign pc_hold      = w_stall;
    assign if_id_hold   = w_stall;
    assign id_ex_bubble = w_stall;
    assign stall_age    = r_stall_age;
    assign issued_cnt   = r_issued_cnt;
    assign stall_cnt    = r_stall_cnt;

endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
- Interlock controller for the five-stage R-type pipeline (IF, ID, EX, MEM, WB), which has no forwarding.
- Keeps a shadow scoreboard of destination register and write enable for the EX, MEM and WB stages.
- Detects read-after-write hazards on the instruction currently in ID.
- Holds the PC and IF_ID and injects a bubble into ID_EX until the producing instruction has written the register file. Also counts issued instructions and stall cycles for performance checks.

Parameters:
- WB_BYPASS, 1: 1 means the register file is write-before-read in the same cycle, so WB is not a hazard source; 0 means WB is a hazard source.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  input  1  pipeline clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- id_valid  input  1  ID holds a real instruction (not a bubble).
- id_rs_addr  input  5  instruction[25:21] from IF_ID.
- id_rt_addr  input  5  instruction[20:16] from IF_ID.
- id_rs_used  input  1  instruction reads rs.
- id_rt_used  input  1  instruction reads rt.
- id_rd_addr  input  5  instruction[15:11] from IF_ID.
- id_reg_w  input  1  Reg_w from Control for the ID instruction.
- ext_hold  input  1  external request to hold the front end.
- pc_hold  output  1  PC must not update this cycle.
- if_id_hold  output  1  IF_ID must retain its contents.
- id_ex_bubble  output  1  ID_EX must capture Reg_w=0 and a NOP.
- stall_age  output  2  consecutive cycles the current ID instruction has been held; saturates at 3.
- issued_cnt  output  CNT_W  instructions that advanced from ID to EX.
- stall_cnt  output  CNT_W  cycles with id_ex_bubble=1.

Behaviour:
- Shadow slots ex_s, mem_s and wb_s each hold {valid, rd[4:0], reg_w}.
- A slot is a hazard source only if valid=1, reg_w=1 and rd!=0.
- hit(src): src != 0 and src equals rd of a hazard source slot among ex_s and mem_s, plus wb_s when WB_BYPASS=0.
- hazard = id_valid and ((id_rs_used and hit(id_rs_addr)) or (id_rt_used and hit(id_rt_addr))). A source that hits several slots is still one hazard.
- stall = hazard or ext_hold.
- pc_hold = if_id_hold = id_ex_bubble = stall. These are combinational in the same cycle, with zero latency from the inputs.
- Each rising edge when rst=0:
  - wb_s <= mem_s and mem_s <= ex_s.
  - ex_s <= invalid when stall=1; otherwise ex_s <= {id_valid, id_rd_addr, id_reg_w}.
- Hazard clears automatically once the producer leaves the last hazard slot:
  - Back-to-back dependence stalls 2 cycles (WB_BYPASS=1) or 3 cycles (WB_BYPASS=0).
  - One independent instruction between producer and consumer: 1 or 2 stall cycles respectively.
- stall_age:
  - Increments (saturating at 3) on each edge with stall=1.
  - Resets to 0 on each edge with stall=0.
- issued_cnt increments when stall=0 and id_valid=1.
- stall_cnt increments when stall=1.
- Both counters saturate at all-ones and never wrap.
- When hazard and ext_hold are asserted together, there is one stall cycle and stall_cnt increments once.
- id_valid=0 with ext_hold=0: no stall, the bubble propagates as invalid, and issued_cnt is unchanged.
- Writes to $0 never create hazards; reads of $0 never hit.
- Reset, including mid-stall:
  - All slots go invalid, and stall_age and both counters go to 0.
  - Outputs are combinational from state and inputs; with the scoreboard empty, stall depends only on ext_hold during and after reset.
- There is no FSM beyond the three-slot shift scoreboard and the stall_age counter.

Decomposition:
- Shared package holds:
  - Slot struct {valid, rd, reg_w}.
  - REG_ZERO = 5'd0.
  - Opcode constant R_TYPE = 6'b000000, used by the bench and the Control-side decode of rs_used/rt_used.
- Natural sub-module: hazard_scoreboard_slot, one pipeline slot register with a synchronous clear. Instantiate it three times.
- The comparison logic and counters stay in the top module.

Test Plan:
- Back-to-back RAW: add $3,$1,$2 then sub $4,$3,$5 with WB_BYPASS=1 -> stall high exactly 2 cycles, sub enters EX on the 3rd cycle, stall_cnt=2, issued_cnt=2. With WB_BYPASS=0 -> 3 stall cycles, stall_cnt=3.
- Distance-2 RAW: add $3,$1,$2; or $6,$7,$8; sub $4,$3,$5 with WB_BYPASS=1 -> exactly 1 stall cycle before sub; stall_age peaks at 1.
- $0 and unused sources:
  - add $0,$1,$2 then sub $4,$0,$0 -> no stall.
  - sll $4,$3,2 (rs_used=0) following a write to rs's register number -> no stall.
- Simultaneous hazard on rs and rt: add $3,$1,$2 then and $5,$3,$3 -> same 2-cycle stall as the single-source case; stall_cnt +2, not +4.
- ext_hold for 5 cycles with no hazard -> pc_hold, if_id_hold and id_ex_bubble high 5 cycles; stall_age saturates at 3; stall_cnt=5; issued_cnt unchanged.
- Reset mid-stall: assert rst during the 1st stall cycle of the back-to-back case -> next cycle all slots are invalid, stall=0, stall_age=0, counters=0; the ID instruction proceeds without stalling.
